// File: rtl/frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
package frame_tx_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDiv   = 4;

  // The receiver relies on these state encodings, so keep them fixed.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_tx_if.sv
// Load/serial-line bundle between a frame source (master) and the transmitter (slave).
interface frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             TXD;
  logic             BUSY;
  logic             DONE;

  modport master (output LD, output D, input TXD, input BUSY, input DONE);
  modport slave  (input LD, input D, output TXD, output BUSY, output DONE);
endinterface

// File: rtl/frame_tx_bit_tick.sv
// Bit-period timer: TICK marks the last cycle of each DIV-cycle bit while enabled.
module bit_tick
  import frame_tx_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic CK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned CW = clog2_min1(DIV);
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (!EN || cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign TICK = (cnt_q == CntLast);

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity,
// stop bit, each held DIV cycles. All line outputs are registered.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIV   = DefDiv,
  parameter int unsigned PAR   = 0
) (
  input  logic       CK,
  input  logic       RST,
  frame_tx_if.slave  bus
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IdxLast = IW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // The timer runs only while a frame is in flight and restarts from 0 on every load.
  bit_tick #(
    .DIV(DIV)
  ) u_tick (
    .CK  (CK),
    .RST (RST),
    .EN  (busy_q),
    .TICK(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.LD) begin
          state_d = S_START;
          shift_d = bus.D;
          par_d   = ^bus.D;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = (PAR != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they register on the same edge.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.TXD  = txd_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: per-cycle {TXD,BUSY,DONE} expectations are queued per frame
// and popped at each falling clock edge.
module tb_frame_tx;

  logic CK = 1'b0;
  logic RST;

  always #5 CK = ~CK;

  frame_tx_if #(.WIDTH(8)) bus0 ();
  frame_tx_if #(.WIDTH(8)) bus1 ();
  frame_tx_if #(.WIDTH(4)) bus2 ();

  frame_tx #(.WIDTH(8), .DIV(4), .PAR(0)) dut0 (.CK(CK), .RST(RST), .bus(bus0));
  frame_tx #(.WIDTH(8), .DIV(4), .PAR(1)) dut1 (.CK(CK), .RST(RST), .bus(bus1));
  frame_tx #(.WIDTH(4), .DIV(1), .PAR(0)) dut2 (.CK(CK), .RST(RST), .bus(bus2));

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  function automatic logic frame_bit(logic [15:0] data, int w, int par, int b);
    logic p;
    p = 1'b0;
    for (int i = 0; i < w; i++) p = p ^ data[i];
    if (b == 0) return 1'b0;
    if (b <= w) return data[b-1];
    if (par != 0 && b == w + 1) return p;
    return 1'b1;
  endfunction

  function automatic logic [2:0] obs(int sel);
    case (sel)
      0:       return {bus0.TXD, bus0.BUSY, bus0.DONE};
      1:       return {bus1.TXD, bus1.BUSY, bus1.DONE};
      default: return {bus2.TXD, bus2.BUSY, bus2.DONE};
    endcase
  endfunction

  task automatic drive(int sel, logic ld, logic [15:0] d);
    case (sel)
      0: begin bus0.LD = ld; bus0.D = d[7:0]; end
      1: begin bus1.LD = ld; bus1.D = d[7:0]; end
      default: begin bus2.LD = ld; bus2.D = d[3:0]; end
    endcase
  endtask

  task automatic check(string tag, int cyc, logic [2:0] o, logic [2:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cycle %0d txd/busy/done got %b expected %b", tag, cyc, o, e);
    end
  endtask

  // mode 0: single frame; 1: extra load mid-frame; 2: LD held for two frames;
  // 3: async reset during data bit 3 (frame abandoned, RST left asserted).
  task automatic run(int sel, int w, int div, int par, logic [15:0] da, logic [15:0] db,
                     int mode, string tag);
    int n;
    int c;
    n = (w + 2 + par) * div;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({frame_bit(da, w, par, i / div), 2'b10});
    exp_q.push_back(3'b101);
    if (mode == 2) begin
      for (int i = 0; i < n; i++) exp_q.push_back({frame_bit(db, w, par, i / div), 2'b10});
      exp_q.push_back(3'b101);
    end
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);

    @(negedge CK);
    drive(sel, 1'b1, da);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge CK);
      if (mode != 2 && c == 0) drive(sel, 1'b0, da);
      if (mode == 1 && c == 12) drive(sel, 1'b1, 16'hFFFF);
      if (mode == 1 && c == 13) drive(sel, 1'b0, 16'hFFFF);
      if (mode == 2 && c == 0) drive(sel, 1'b1, db);
      if (mode == 2 && c == 2 * n + 1) drive(sel, 1'b0, db);
      check(tag, c, obs(sel), exp_q.pop_front());
      if (mode == 3 && c == 17) begin
        #1 RST = 1'b1;
        #1 check({tag, "_async"}, c, obs(sel), 3'b100);
        exp_q.delete();
      end
      c++;
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    drive(2, 1'b0, 16'h0);
    @(negedge CK);
    check("reset0", 0, obs(0), 3'b100);
    check("reset1", 0, obs(1), 3'b100);
    check("reset2", 0, obs(2), 3'b100);
    @(negedge CK);
    RST = 1'b0;

    run(0, 8, 4, 0, 16'hA5, 16'h0, 0, "basic");
    run(1, 8, 4, 1, 16'h07, 16'h0, 0, "parity");
    run(0, 8, 4, 0, 16'h00, 16'h0, 1, "ignored_ld");
    run(0, 8, 4, 0, 16'h3C, 16'hC3, 2, "back2back");
    run(0, 8, 4, 0, 16'h5A, 16'h0, 3, "mid_reset");
    @(negedge CK);
    check("held_reset", 0, obs(0), 3'b100);
    RST = 1'b0;
    run(0, 8, 4, 0, 16'h96, 16'h0, 0, "post_reset");
    run(2, 4, 1, 0, 16'h9, 16'h0, 0, "div1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
